// File: rtl/weekday_seg_scanner_if.sv
// Control and display bus of the weekday set-day unit.
// master: calendar/board side. slave: the scanner.
interface weekday_seg_scanner_if #(
  parameter int unsigned NUM_DIGITS = 3
);
  logic                  day_tick;
  logic                  load_en;
  logic [2:0]            load_day;
  logic                  set_mode;
  logic                  set_inc;
  logic                  set_dec;
  logic [2:0]            day_out;
  logic [6:0]            seg;
  logic [NUM_DIGITS-1:0] digit_en;

  modport master (
    output day_tick, load_en, load_day, set_mode, set_inc, set_dec,
    input  day_out, seg, digit_en
  );

  modport slave (
    input  day_tick, load_en, load_day, set_mode, set_inc, set_dec,
    output day_out, seg, digit_en
  );
endinterface

// File: rtl/weekday_seg_scanner.sv
// Weekday register with a time-multiplexed seven-segment display
// of its three-letter abbreviation, plus blinking manual-set mode.
module weekday_seg_scanner #(
  parameter int unsigned NUM_DIGITS = 3,
  parameter int unsigned SCAN_DIV   = 1000,
  parameter int unsigned BLINK_DIV  = 50000,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  weekday_seg_scanner_if.slave bus
);

  localparam int unsigned IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned BLINK_W = $clog2(BLINK_DIV);

  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_HALF = BLINK_W'(BLINK_DIV / 2);

  localparam logic [6:0] G_M = 7'b1110110;
  localparam logic [6:0] G_O = 7'b1111110;
  localparam logic [6:0] G_N = 7'b0010101;
  localparam logic [6:0] G_T = 7'b0001111;
  localparam logic [6:0] G_U = 7'b0111110;
  localparam logic [6:0] G_E = 7'b1001111;
  localparam logic [6:0] G_W = 7'b0101010;
  localparam logic [6:0] G_D = 7'b0111101;
  localparam logic [6:0] G_H = 7'b0110111;
  localparam logic [6:0] G_F = 7'b1000111;
  localparam logic [6:0] G_R = 7'b0000101;
  localparam logic [6:0] G_I = 7'b0110000;
  localparam logic [6:0] G_S = 7'b1011011;
  localparam logic [6:0] G_A = 7'b1110111;

  logic [2:0]            day_q,   day_d;
  logic [IDX_W-1:0]      idx_q,   idx_d;
  logic [SCAN_W-1:0]     cnt_q,   cnt_d;
  logic [BLINK_W-1:0]    blink_q, blink_d;
  logic [6:0]            seg_q,   seg_d;
  logic [NUM_DIGITS-1:0] en_q,    en_d;

  logic [2:0] day_inc_c;
  logic [2:0] day_dec_c;
  logic       blank_c;

  // Letter k of the abbreviation for the given day; day 7 never occurs.
  function automatic logic [6:0] glyph(input logic [2:0] day, input logic [IDX_W-1:0] idx);
    logic [20:0] word;
    logic [1:0]  k;
    k = 2'(idx);
    case (day)
      3'd0:    word = {G_M, G_O, G_N};
      3'd1:    word = {G_T, G_U, G_E};
      3'd2:    word = {G_W, G_E, G_D};
      3'd3:    word = {G_T, G_H, G_U};
      3'd4:    word = {G_F, G_R, G_I};
      3'd5:    word = {G_S, G_A, G_T};
      3'd6:    word = {G_S, G_U, G_N};
      default: word = '0;
    endcase
    case (k)
      2'd0:    glyph = word[20:14];
      2'd1:    glyph = word[13:7];
      default: glyph = word[6:0];
    endcase
  endfunction

  assign day_inc_c = (day_q == 3'd6) ? 3'd0 : day_q + 3'd1;
  assign day_dec_c = (day_q == 3'd0) ? 3'd6 : day_q - 3'd1;
  assign blank_c   = bus.set_mode && (blink_q >= BLINK_HALF);

  // Day update: load beats set mode beats the calendar tick.
  always_comb begin
    day_d = day_q;
    if (bus.load_en) begin
      if (bus.load_day != 3'd7) day_d = bus.load_day;
    end else if (bus.set_mode) begin
      if (bus.set_inc && !bus.set_dec)      day_d = day_inc_c;
      else if (bus.set_dec && !bus.set_inc) day_d = day_dec_c;
    end else if (bus.day_tick) begin
      day_d = day_inc_c;
    end
  end

  // Scan, blink and display next-state.
  always_comb begin
    cnt_d   = (cnt_q == SCAN_LAST) ? '0 : cnt_q + SCAN_W'(1);
    idx_d   = idx_q;
    if (cnt_q == SCAN_LAST) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    blink_d = '0;
    if (bus.set_mode) blink_d = (blink_q == BLINK_LAST) ? '0 : blink_q + BLINK_W'(1);
    seg_d   = blank_c ? 7'b0 : glyph(day_q, idx_q);
    en_d    = NUM_DIGITS'(1) << idx_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      day_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      blink_q <= '0;
      seg_q   <= {7{ACTIVE_LOW}};
      en_q    <= {NUM_DIGITS{ACTIVE_LOW}};
    end else begin
      day_q   <= day_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      blink_q <= blink_d;
      seg_q   <= seg_d ^ {7{ACTIVE_LOW}};
      en_q    <= en_d ^ {NUM_DIGITS{ACTIVE_LOW}};
    end
  end

  assign bus.day_out  = day_q;
  assign bus.seg      = seg_q;
  assign bus.digit_en = en_q;

endmodule

// File: tb/tb_weekday_seg_scanner.sv
// Directed checks of day register, scan, glyphs, blink and pin polarity.
module tb_weekday_seg_scanner;

  localparam logic [6:0] G_M = 7'b1110110;
  localparam logic [6:0] G_O = 7'b1111110;
  localparam logic [6:0] G_N = 7'b0010101;
  localparam logic [6:0] G_W = 7'b0101010;
  localparam logic [6:0] G_F = 7'b1000111;
  localparam logic [6:0] G_R = 7'b0000101;
  localparam logic [6:0] G_I = 7'b0110000;
  localparam logic [6:0] G_S = 7'b1011011;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  weekday_seg_scanner_if #(.NUM_DIGITS(3)) bus ();
  weekday_seg_scanner_if #(.NUM_DIGITS(3)) bus_l ();

  assign bus_l.day_tick = bus.day_tick;
  assign bus_l.load_en  = bus.load_en;
  assign bus_l.load_day = bus.load_day;
  assign bus_l.set_mode = bus.set_mode;
  assign bus_l.set_inc  = bus.set_inc;
  assign bus_l.set_dec  = bus.set_dec;

  weekday_seg_scanner #(.NUM_DIGITS(3), .SCAN_DIV(4), .BLINK_DIV(8), .ACTIVE_LOW(1'b0)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus)
  );

  weekday_seg_scanner #(.NUM_DIGITS(3), .SCAN_DIV(4), .BLINK_DIV(8), .ACTIVE_LOW(1'b1)) dut_l (
    .clk_i(clk), .rst_i(rst), .bus(bus_l)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // T1 + T6: reset state then a full scan of MON on both polarities.
  task automatic test_reset();
    logic [6:0] mon [3];
    logic [6:0] exp_seg;
    logic [2:0] exp_en;
    int         idx;
    mon[0] = G_M; mon[1] = G_O; mon[2] = G_N;
    do_reset();
    checks++;
    if (bus.seg !== 7'b0 || bus.digit_en !== 3'b000 || bus.day_out !== 3'd0) begin
      errors++;
      $display("FAIL reset_state: seg=%b en=%b day=%0d, want 0000000 000 0", bus.seg, bus.digit_en, bus.day_out);
    end
    checks++;
    if (bus_l.seg !== 7'b1111111 || bus_l.digit_en !== 3'b111) begin
      errors++;
      $display("FAIL reset_pins_al: seg=%b en=%b, want 1111111 111", bus_l.seg, bus_l.digit_en);
    end
    for (int c = 0; c < 13; c++) begin
      step();
      idx     = (c / 4) % 3;
      exp_seg = mon[idx];
      exp_en  = 3'b001 << idx;
      checks++;
      if (bus.seg !== exp_seg || bus.digit_en !== exp_en) begin
        errors++;
        $display("FAIL scan c=%0d: seg=%b en=%b, want %b %b", c, bus.seg, bus.digit_en, exp_seg, exp_en);
      end
      checks++;
      if (bus_l.seg !== ~exp_seg || bus_l.digit_en !== ~exp_en) begin
        errors++;
        $display("FAIL scan_al c=%0d: seg=%b en=%b, want %b %b", c, bus_l.seg, bus_l.digit_en, ~exp_seg, ~exp_en);
      end
    end
  endtask

  // T2: seven ticks wrap the week; WED shows W on digit 0.
  task automatic test_day_tick();
    logic [2:0] exp_day;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      bus.day_tick = 1'b1;
      step();
      bus.day_tick = 1'b0;
      exp_day = 3'((i + 1) % 7);
      checks++;
      if (bus.day_out !== exp_day) begin
        errors++;
        $display("FAIL tick %0d: day=%0d, want %0d", i + 1, bus.day_out, exp_day);
      end
      if (i == 1) begin
        step();
        checks++;
        if (bus.seg !== G_W || bus.digit_en !== 3'b001) begin
          errors++;
          $display("FAIL wed_glyph: seg=%b en=%b, want %b 001", bus.seg, bus.digit_en, G_W);
        end
      end
    end
  endtask

  // T3: manual set inc/dec with wrap, simultaneous press, lost tick.
  task automatic test_set_mode();
    do_reset();
    bus.set_mode = 1'b1;
    bus.set_dec  = 1'b1;
    step();
    bus.set_dec  = 1'b0;
    checks++;
    if (bus.day_out !== 3'd6) begin
      errors++;
      $display("FAIL set_dec_wrap: day=%0d, want 6", bus.day_out);
    end
    step();
    checks++;
    if (bus.seg !== G_S) begin
      errors++;
      $display("FAIL sun_glyph: seg=%b, want %b", bus.seg, G_S);
    end
    bus.set_inc = 1'b1;
    step();
    bus.set_inc = 1'b0;
    checks++;
    if (bus.day_out !== 3'd0) begin
      errors++;
      $display("FAIL set_inc_wrap: day=%0d, want 0", bus.day_out);
    end
    bus.set_inc = 1'b1;
    bus.set_dec = 1'b1;
    step();
    bus.set_inc = 1'b0;
    bus.set_dec = 1'b0;
    checks++;
    if (bus.day_out !== 3'd0) begin
      errors++;
      $display("FAIL inc_dec_both: day=%0d, want 0", bus.day_out);
    end
    bus.day_tick = 1'b1;
    step();
    bus.day_tick = 1'b0;
    checks++;
    if (bus.day_out !== 3'd0) begin
      errors++;
      $display("FAIL tick_in_set: day=%0d, want 0", bus.day_out);
    end
    bus.set_mode = 1'b0;
    bus.set_inc  = 1'b1;
    step();
    bus.set_inc  = 1'b0;
    checks++;
    if (bus.day_out !== 3'd0) begin
      errors++;
      $display("FAIL inc_outside_set: day=%0d, want 0", bus.day_out);
    end
  endtask

  // T4: direct load, FRI glyph scan, invalid load and load priority.
  task automatic test_load();
    do_reset();
    bus.load_en  = 1'b1;
    bus.load_day = 3'd4;
    step();
    bus.load_en  = 1'b0;
    checks++;
    if (bus.day_out !== 3'd4) begin
      errors++;
      $display("FAIL load_fri: day=%0d, want 4", bus.day_out);
    end
    step();
    checks++;
    if (bus.seg !== G_F || bus.digit_en !== 3'b001) begin
      errors++;
      $display("FAIL fri_f: seg=%b en=%b, want %b 001", bus.seg, bus.digit_en, G_F);
    end
    repeat (3) step();
    checks++;
    if (bus.seg !== G_R || bus.digit_en !== 3'b010) begin
      errors++;
      $display("FAIL fri_r: seg=%b en=%b, want %b 010", bus.seg, bus.digit_en, G_R);
    end
    repeat (4) step();
    checks++;
    if (bus.seg !== G_I || bus.digit_en !== 3'b100) begin
      errors++;
      $display("FAIL fri_i: seg=%b en=%b, want %b 100", bus.seg, bus.digit_en, G_I);
    end
    bus.load_en  = 1'b1;
    bus.load_day = 3'd7;
    step();
    checks++;
    if (bus.day_out !== 3'd4) begin
      errors++;
      $display("FAIL load_7: day=%0d, want 4", bus.day_out);
    end
    bus.load_day = 3'd2;
    bus.day_tick = 1'b1;
    step();
    bus.day_tick = 1'b0;
    checks++;
    if (bus.day_out !== 3'd2) begin
      errors++;
      $display("FAIL load_vs_tick: day=%0d, want 2", bus.day_out);
    end
    bus.load_day = 3'd5;
    bus.set_mode = 1'b1;
    bus.set_inc  = 1'b1;
    step();
    checks++;
    if (bus.day_out !== 3'd5) begin
      errors++;
      $display("FAIL load_vs_set: day=%0d, want 5", bus.day_out);
    end
    bus.load_day = 3'd7;
    step();
    bus.load_en  = 1'b0;
    bus.set_inc  = 1'b0;
    bus.set_mode = 1'b0;
    checks++;
    if (bus.day_out !== 3'd5) begin
      errors++;
      $display("FAIL load_7_blocks_inc: day=%0d, want 5", bus.day_out);
    end
  endtask

  // T5: blink with BLINK_DIV=8; digit enables keep scanning while blanked.
  task automatic test_blink();
    logic [6:0] mon [3];
    logic [6:0] exp_seg;
    logic [2:0] exp_en;
    int         idx;
    mon[0] = G_M; mon[1] = G_O; mon[2] = G_N;
    do_reset();
    bus.set_mode = 1'b1;
    for (int n = 1; n <= 14; n++) begin
      step();
      idx     = ((n - 1) / 4) % 3;
      exp_en  = 3'b001 << idx;
      exp_seg = (((n - 1) % 8) >= 4) ? 7'b0 : mon[idx];
      checks++;
      if (bus.seg !== exp_seg || bus.digit_en !== exp_en) begin
        errors++;
        $display("FAIL blink n=%0d: seg=%b en=%b, want %b %b", n, bus.seg, bus.digit_en, exp_seg, exp_en);
      end
      if (n == 6) begin
        checks++;
        if (bus_l.seg !== 7'b1111111 || bus_l.digit_en !== 3'b101) begin
          errors++;
          $display("FAIL blink_al: seg=%b en=%b, want 1111111 101", bus_l.seg, bus_l.digit_en);
        end
      end
    end
    bus.set_mode = 1'b0;
    step();
    checks++;
    if (bus.seg !== G_M || bus.digit_en !== 3'b001) begin
      errors++;
      $display("FAIL blink_exit: seg=%b en=%b, want %b 001", bus.seg, bus.digit_en, G_M);
    end
  endtask

  initial begin
    rst          = 1'b1;
    bus.day_tick = 1'b0;
    bus.load_en  = 1'b0;
    bus.load_day = 3'd0;
    bus.set_mode = 1'b0;
    bus.set_inc  = 1'b0;
    bus.set_dec  = 1'b0;
    step();
    test_reset();
    test_day_tick();
    test_set_mode();
    test_load();
    test_blink();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
